// File: rtl/csa_accumulator_pkg.sv
// Shared defaults and state encoding for the carry-save accumulator.
package csa_accumulator_pkg;
  localparam int WIDTH_DEF = 14;
  localparam int CNTW_DEF  = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_e;
endpackage

// File: rtl/csa_row_3to2.sv
// Combinational 3:2 compressor: folds two carry-save rows and one operand
// into a new sum row and a carry row (carry weighted one bit up).
module csa_row_3to2
  import csa_accumulator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o
);
  logic [WIDTH-1:0] maj;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign sum_o[gi] = s_i[gi] ^ c_i[gi] ^ d_i[gi];
    assign maj[gi]   = (s_i[gi] & c_i[gi]) | (s_i[gi] & d_i[gi]) | (c_i[gi] & d_i[gi]);
  end

  // The top carry falls off: rows are kept modulo 2^WIDTH.
  assign carry_o = maj << 1;
endmodule

// File: rtl/csa_accumulator.sv
// Accumulates a batch of operands in carry-save form and presents the two
// rows plus operand count to a downstream final adder.
module csa_accumulator
  import csa_accumulator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_row0,
  output logic [WIDTH-1:0] out_row1,
  output logic [CNTW-1:0]  out_count
);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  state_e           state_q;
  logic [WIDTH-1:0] row0_q, row1_q;
  logic [WIDTH-1:0] row0_d, row1_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             in_ready_q, out_valid_q;
  logic             accept;

  csa_row_3to2 #(.WIDTH(WIDTH)) u_row (
    .s_i    (row0_q),
    .c_i    (row1_q),
    .d_i    (in_data),
    .sum_o  (row0_d),
    .carry_o(row1_d)
  );

  assign accept  = in_valid & in_ready_q;
  assign count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      row0_q      <= '0;
      row1_q      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            row0_q  <= row0_d;
            row1_q  <= row1_d;
            count_q <= count_d;
            if (in_last) begin
              state_q     <= DRAIN;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // Rows and count hold until the final adder takes them.
          if (out_ready) begin
            state_q     <= ACCUM;
            row0_q      <= '0;
            row1_q      <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_row0  = row0_q;
  assign out_row1  = row1_q;
  assign out_count = count_q;
endmodule
